// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the 8-bit APB link.
//   APB_DATA_W / APB_ADDR_W : default bus widths
//   APB_CNT_W               : width of the completer wait-state counter
//   apb_slv_state_t         : completer FSM states (IDLE, ACCESS)
package apb_pkg;

    localparam int APB_DATA_W = 8;
    localparam int APB_ADDR_W = 8;
    localparam int APB_CNT_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_t;

endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: DEPTH x DATA_WIDTH register storage for the APB completer.
//   pclk   in   clock, writes on rising edge
//   preset in   asynchronous active-high clear of every entry
//   we     in   write enable
//   addr   in   entry index, shared by the write and the read port
//   wdata  in   write data
//   rdata  out  asynchronous read of mem[addr]
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // The top only consumes rdata for in-range addresses.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/apb_slave.sv
// apb_slave: APB completer with configurable wait states and a local register file.
//   pclk     in   bus clock
//   preset   in   asynchronous active-high reset
//   psel     in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   transfer address
//   pwdata   in   write data
//   prdata   out  read data, non-zero only in the pready cycle of an in-range read
//   pready   out  transfer-complete strobe
//   pslverr  out  error response for addresses >= DEPTH, only with pready
module apb_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int ADDR_WIDTH  = APB_ADDR_W,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]  DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [APB_CNT_W-1:0] WAIT_LD = APB_CNT_W'(WAIT_CYCLES);

    apb_slv_state_t        state_q, state_d;
    logic [APB_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  setup;
    logic                  complete;
    logic                  in_range;
    logic                  capture;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;

    assign setup    = psel && !penable;
    assign in_range = ({1'b0, addr_q} < DEPTH_X);
    // psel gating lets an abort suppress the response in the same cycle.
    assign complete = (state_q == ACCESS) && psel && (cnt_q == '0);
    assign wr_en    = complete && write_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                // penable without a preceding setup phase is ignored here.
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LD;
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    if (penable) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (setup) begin
                    // Completing edge that is also a setup edge: chain the next transfer.
                    cnt_d   = WAIT_LD;
                    capture = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        if (capture) begin
            addr_d  = paddr;
            write_d = pwrite;
            wdata_d = pwdata;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Captured transfer fields are only consumed while in ACCESS, so they need no reset.
    always_ff @(posedge pclk) begin
        addr_q  <= addr_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
    end

    apb_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .pclk  (pclk),
        .preset(preset),
        .we    (wr_en),
        .addr  (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    assign pready  = complete;
    assign pslverr = complete && !in_range;
    assign prdata  = (complete && !write_q && in_range) ? rd_data : '0;

endmodule

// File: tb/tb_apb_slave.sv
module tb_apb_slave;

    logic       pclk = 1'b0;
    logic       preset;
    logic       psel    [3];
    logic       penable [3];
    logic       pwrite  [3];
    logic [7:0] paddr   [3];
    logic [7:0] pwdata  [3];
    logic [7:0] prdata  [3];
    logic       pready  [3];
    logic       pslverr [3];

    int checks   = 0;
    int failures = 0;

    // Expected register contents per DUT instance.
    logic [7:0] model [3][16];

    always #5 pclk = ~pclk;

    apb_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

    apb_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(1)) dut1 (
        .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

    apb_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(3)) dut2 (
        .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One full transfer on instance d; entered and left 1 time unit after a rising edge.
    // mode 0: bus held stable, 1: address/data/direction randomised during access,
    // mode 2: pwdata changed to wd^0x33 during access.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input int mode, output logic [7:0] rd, output bit err,
                        output int waits, output bit ok, output bit quiet);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        tick();
        penable[d] = 1'b1;
        if (mode == 2) pwdata[d] = wd ^ 8'h33;
        waits = 0;
        ok    = 1'b0;
        quiet = 1'b1;
        rd    = 8'h00;
        err   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mode == 1) begin
                pwdata[d] = 8'($urandom);
                paddr[d]  = 8'($urandom);
                pwrite[d] = 1'($urandom);
            end
            #3;
            if (pready[d] === 1'b1) begin
                rd  = prdata[d];
                err = pslverr[d];
                ok  = 1'b1;
            end else if (prdata[d] !== 8'h00 || pslverr[d] !== 1'b0) begin
                quiet = 1'b0;
            end
            tick();
            if (ok) break;
            waits++;
        end
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // Transfer checked against the register model.
    task automatic do_xfer(input int d, input bit wr, input logic [7:0] a,
                           input logic [7:0] wd, input int mode);
        logic [7:0] rd, exp_rd;
        bit         err, ok, quiet, exp_err;
        int         waits;
        string      tag;
        exp_err = (a >= 8'd16);
        exp_rd  = (!wr && !exp_err) ? model[d][a[3:0]] : 8'h00;
        tag     = $sformatf("d%0d %s a=%02h", d, wr ? "wr" : "rd", a);
        xfer(d, wr, a, wd, mode, rd, err, waits, ok, quiet);
        chk({tag, " completed"}, ok, 1);
        if (ok) begin
            chk({tag, " wait states"}, waits, wait_of(d));
            chk({tag, " pslverr"}, err, exp_err);
            if (!wr) chk({tag, " prdata"}, rd, exp_rd);
            chk({tag, " quiet while waiting"}, quiet, 1);
        end
        if (wr && !exp_err) model[d][a[3:0]] = wd;
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit         err, ok, quiet;
        int         waits;

        vecs[0] = '{1'b1, 8'h05, 8'hA5, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h05, 8'h00, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 8'h10, 8'h3C, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 8'h0F, 8'h5A, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 8'h0F, 8'h00, 8'h5A, 1'b0};
        vecs[7] = '{1'b1, 8'hFF, 8'h99, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 8'h0F, 8'h00, 8'h5A, 1'b0};

        preset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 8'h00; pwdata[d] = 8'h00;
            for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
        end
        repeat (3) @(posedge pclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset d%0d pready", d), pready[d], 0);
            chk($sformatf("reset d%0d pslverr", d), pslverr[d], 0);
            chk($sformatf("reset d%0d prdata", d), prdata[d], 0);
        end
        preset = 1'b0;
        tick();

        // Zero-wait read straight after reset.
        do_xfer(0, 1'b0, 8'h03, 8'h00, 0);

        // Table vectors, back-to-back on the one-wait instance.
        for (int i = 0; i < 9; i++) begin
            xfer(1, vecs[i].wr, vecs[i].a, vecs[i].wd, 0, rd, err, waits, ok, quiet);
            chk($sformatf("vec%0d completed", i), ok, 1);
            chk($sformatf("vec%0d wait states", i), waits, 1);
            chk($sformatf("vec%0d pslverr", i), err, vecs[i].exp_err);
            if (!vecs[i].wr) chk($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
            if (vecs[i].wr && !vecs[i].exp_err) model[1][vecs[i].a[3:0]] = vecs[i].wd;
        end
        // Error writes must leave every register untouched.
        for (int a = 0; a < 16; a++) do_xfer(1, 1'b0, 8'(a), 8'h00, 0);

        // Three wait states on a read of 0x00.
        xfer(2, 1'b0, 8'h00, 8'h00, 0, rd, err, waits, ok, quiet);
        chk("wait3 completed", ok, 1);
        chk("wait3 low cycles", waits, 3);
        chk("wait3 prdata", rd, 8'h00);

        // Write data is held from the setup edge.
        xfer(1, 1'b1, 8'h02, 8'h11, 2, rd, err, waits, ok, quiet);
        model[1][2] = 8'h11;
        xfer(1, 1'b0, 8'h02, 8'h00, 0, rd, err, waits, ok, quiet);
        chk("data hold read", rd, 8'h11);

        // Abort mid-wait on the three-wait instance.
        do_xfer(2, 1'b1, 8'h01, 8'h44, 0);
        tick();
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 8'h01; pwdata[2] = 8'h99;
        tick();
        penable[2] = 1'b1;
        #3;
        chk("abort wait pready", pready[2], 0);
        tick();
        psel[2] = 1'b0;
        #3;
        chk("abort cycle pready", pready[2], 0);
        tick();
        penable[2] = 1'b0;
        tick();
        // penable with psel but no setup phase while idle is ignored.
        psel[2] = 1'b1; penable[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #3;
            chk($sformatf("idle penable c%0d pready", c), pready[2], 0);
            tick();
        end
        psel[2] = 1'b0; penable[2] = 1'b0;
        tick();
        xfer(2, 1'b0, 8'h01, 8'h00, 0, rd, err, waits, ok, quiet);
        chk("abort no write", rd, 8'h44);
        chk("after abort wait states", waits, 3);

        // Randomised traffic against the register model.
        for (int n = 0; n < 300; n++) begin
            int d;
            d = $urandom_range(0, 2);
            do_xfer(d, 1'($urandom), 8'($urandom_range(0, 19)), 8'($urandom),
                    $urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end

        // Reset in the pready cycle of a read while another instance is mid-write.
        do_xfer(0, 1'b1, 8'h04, 8'h77, 0);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h04;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h06;
        pwdata[2] = 8'h66;
        tick();
        penable[0] = 1'b1;
        penable[2] = 1'b1;
        #3;
        chk("pre-reset pready", pready[0], 1);
        chk("pre-reset prdata", prdata[0], 8'h77);
        preset = 1'b1;
        #1;
        chk("reset pready at once", pready[0], 0);
        chk("reset prdata at once", prdata[0], 0);
        chk("reset pslverr at once", pslverr[0], 0);
        tick();
        preset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
            for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
        end
        tick();
        xfer(0, 1'b0, 8'h04, 8'h00, 0, rd, err, waits, ok, quiet);
        chk("reset cleared 0x04", rd, 8'h00);
        xfer(2, 1'b0, 8'h06, 8'h00, 0, rd, err, waits, ok, quiet);
        chk("reset lost pending write", rd, 8'h00);
        for (int d = 0; d < 3; d++) begin
            do_xfer(d, 1'b0, 8'h05, 8'h00, 0);
            do_xfer(d, 1'b0, 8'h0F, 8'h00, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
# apb_slave

Completer (slave) end of the team's 8-bit APB link: samples the setup and access phases driven by the APB master, inserts a configurable number of wait states, and commits writes to or returns reads from a local register file. Out-of-range addresses complete with an error response. The block sits on the same bus as the master and is the reference target for master-side integration tests.

## Interface
- `DATA_WIDTH`, 8, width of `pwdata`/`prdata` and of each register
- `ADDR_WIDTH`, 8, width of `paddr`
- `DEPTH`, 16, number of registers; valid addresses are `0..DEPTH-1`, and `DEPTH` must be `<= 2**ADDR_WIDTH`
- `WAIT_CYCLES`, 1, wait states per transfer, range 0..15
- `pclk`  in  1  bus clock; all state changes on the rising edge
- `preset`  in  1  reset, asynchronous, active-high
- `psel`  in  1  slave select from master
- `penable`  in  1  access-phase indicator from master
- `pwrite`  in  1  1 = write, 0 = read
- `paddr`  in  `ADDR_WIDTH`  transfer address
- `pwdata`  in  `DATA_WIDTH`  write data
- `prdata`  out  `DATA_WIDTH`  read data, valid only while `pready=1` on a read
- `pready`  out  1  transfer-complete strobe
- `pslverr`  out  1  error response, valid only while `pready=1`

## Operation
- FSM states:
  - `IDLE`: no transfer in progress.
  - `ACCESS`: a transfer has been captured and its wait counter is running.
- `IDLE` → `ACCESS` at an edge where `psel=1` and `penable=0` (setup phase).
  - On that edge, capture `paddr`, `pwrite` and `pwdata` into `addr_q`, `write_q` and `wdata_q`.
  - On that edge, load the wait counter with `WAIT_CYCLES`.
- In `ACCESS` with `psel=1` and `penable=1`:
  - While counter ≠ 0, decrement it; `pready=0`.
  - When counter = 0, `pready=1` for that cycle and the transfer completes at the next edge.
- Completion:
  - If `addr_q < DEPTH` and `write_q=1`, `wdata_q` is written to `mem[addr_q]` at the completing edge.
  - If `addr_q < DEPTH` and `write_q=0`, `prdata = mem[addr_q]` during the `pready` cycle.
  - If `addr_q >= DEPTH`: `pslverr=1` and `prdata=0` in the `pready` cycle, and no register is modified.
- After completion, with `psel=1` and `penable=0` at the completing edge: recapture the new transfer and stay in `ACCESS` (back-to-back transfers, no idle cycle).
- After completion with `psel=0`: go to `IDLE`.
- Protocol abort: `psel=0` at any edge in `ACCESS` → `IDLE`, no write, no response.
- Address, data and direction are taken only from the captured copies. Changes on `paddr`, `pwdata` or `pwrite` during the access phase are ignored.
- `pready`, `pslverr` and `prdata` are 0 whenever no completion is occurring.

## Timing
- Reset (asynchronous, active-high): state=`IDLE`, counter=0, all `mem` entries=0.
  - `prdata=0`, `pready=0`, `pslverr=0`.
  - Reset asserted mid-transfer aborts it; the pending write is lost.
- The access phase lasts `WAIT_CYCLES+1` cycles. `WAIT_CYCLES=0` gives a zero-wait transfer: `pready=1` in the first `penable` cycle.
- `pready`, `pslverr` and `prdata` are decoded from registered state, counter and `addr_q`. There is no combinational path from `psel`/`penable` to the outputs beyond the `psel` gating that is required.
- Write data is visible to a read whose setup edge is at or after the completing edge of the write (read-after-write, 0 extra cycles).
- `penable=1` while in `IDLE` is ignored.
- Counter width is 4 bits; it never wraps, because it is only decremented while ≠ 0.

## Structure
- Shared package `apb_pkg`:
  - State enum `apb_slv_state_t` (`IDLE`, `ACCESS`).
  - Constants `APB_DATA_W=8`, `APB_ADDR_W=8`.
- Sub-module `apb_regfile`: `DEPTH` × `DATA_WIDTH` storage with synchronous write enable, asynchronous read, and asynchronous clear on `preset`.
- Top level holds the FSM, wait counter, capture registers, range check and response muxing.

## Test plan
- Reset then read: `WAIT_CYCLES=0`, read `paddr=0x03` → `pready=1` in the first access cycle, `prdata=0x00`, `pslverr=0`.
- Write then read: `WAIT_CYCLES=1`, write `0xA5` to `0x05` → `pready` low for 1 access cycle then high. Back-to-back read of `0x05` → `prdata=0xA5`.
- Out of range: write `0x3C` to `0x10` with `DEPTH=16` → `pslverr=1` with `pready`, and all registers unchanged. Read of `0x10` → `prdata=0x00`, `pslverr=1`.
- Wait count: `WAIT_CYCLES=3`, read of `0x00` → exactly 3 cycles with `pready=0`, then 1 cycle with `pready=1`.
- Data hold: change `pwdata` from `0x11` to `0x22` during the wait states of a write to `0x02` → a later read of `0x02` returns `0x11`.
- Abort and reset: drop `psel` mid-wait on a write to `0x01` → no write, FSM returns to `IDLE`. Assert `preset` mid-write → outputs 0 at once and memory cleared.
